// File: rtl/spike_pkt_pkg.sv
// Shared definitions for the spike packet receive path: packet field layout,
// decode FSM states and the saturating counter helper.
package spike_pkt_pkg;

  localparam int PKT_W   = 32;
  localparam int AXON_W  = 16;
  localparam int COORD_W = 4;

  // Packet field positions (bit 31 is the MSB of the packet)
  localparam int DEST_X_MSB     = 31;
  localparam int DEST_X_LSB     = 28;
  localparam int DEST_Y_MSB     = 27;
  localparam int DEST_Y_LSB     = 24;
  localparam int SRC_X_MSB      = 23;
  localparam int SRC_X_LSB      = 20;
  localparam int SRC_Y_MSB      = 19;
  localparam int SRC_Y_LSB      = 16;
  localparam int SRC_NEURON_MSB = 15;
  localparam int SRC_NEURON_LSB = 8;
  localparam int RSVD_MSB       = 7;
  localparam int RSVD_LSB       = 0;

  // The axon index is the contiguous source identity {src_x, src_y, src_neuron}
  localparam int AXON_MSB = SRC_X_MSB;
  localparam int AXON_LSB = SRC_NEURON_LSB;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DELIVER
  } rx_state_e;

  // Increment a counter of the given width, sticking at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] maxVal;
    if (width >= 32) begin
      maxVal = '1;
    end else begin
      maxVal = (32'd1 << width) - 32'd1;
    end
    if (value >= maxVal) begin
      return maxVal;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/spike_rx_fifo.sv
// Small receive FIFO for spike packets. Full is a registered flag derived from
// the next occupancy so that a pop never reaches pkt_full combinationally; a
// push offered while full is refused even if a pop happens in the same cycle.
module spike_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             full_q;
  logic             pushOk;
  logic             popOk;

  // Qualify requests against the current flags and work out the next occupancy
  always_comb begin
    pushOk  = push_i && !full_q;
    popOk   = pop_i && (level_q != '0);
    level_d = level_q;
    if (pushOk && !popOk) begin
      level_d = level_q + 1'b1;
    end else if (!pushOk && popOk) begin
      level_d = level_q - 1'b1;
    end
  end

  // Packet storage; contents need no reset because occupancy guards every read
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers (wrapping naturally at the power-of-two depth), level and full flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (pushOk) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (popOk) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;

endmodule

// File: rtl/spike_packet_receiver.sv
// Receive endpoint of the neuron/router local port. Packets are buffered in a
// small FIFO, one at a time moved into a hold register, checked against this
// tile's address and delivered to the neuron core as an axon index.
module spike_packet_receiver
  import spike_pkt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COORD_W-1:0]       local_x,
  input  logic [COORD_W-1:0]       local_y,
  input  logic [PKT_W-1:0]         pkt_in,
  input  logic                     pkt_write,
  output logic                     pkt_full,
  output logic                     spike_valid,
  output logic [AXON_W-1:0]        spike_axon,
  input  logic                     spike_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic [CNT_W-1:0]         misroute_cnt
);

  rx_state_e         state_q;
  logic [PKT_W-1:0]  hold_q;
  logic              spike_valid_q;
  logic [AXON_W-1:0] spike_axon_q;
  logic [CNT_W-1:0]  overflow_cnt_q;
  logic [CNT_W-1:0]  overflow_cnt_d;
  logic [CNT_W-1:0]  misroute_cnt_q;
  logic [CNT_W-1:0]  misroute_cnt_d;

  logic [PKT_W-1:0]  fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPop;
  logic              destMatch;
  logic              misrouteEvent;
  logic              overflowEvent;
  logic              unusedReserved;

  spike_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (pkt_write),
    .push_data_i (pkt_in),
    .pop_i       (fifoPop),
    .pop_data_o  (fifoHead),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty),
    .level_o     (fifo_level)
  );

  // The reserved byte travels with the packet but carries no meaning here
  assign unusedReserved = ^hold_q[RSVD_MSB:RSVD_LSB];

  // Decode-side qualifiers: when to pull the head, and whether the held packet is ours
  always_comb begin
    fifoPop       = (state_q == IDLE) && !fifoEmpty;
    destMatch     = (hold_q[DEST_X_MSB:DEST_X_LSB] == local_x) &&
                    (hold_q[DEST_Y_MSB:DEST_Y_LSB] == local_y);
    misrouteEvent = (state_q == CHECK) && !destMatch;
    overflowEvent = pkt_write && fifoFull;
  end

  // One packet in flight: pop into the hold register, check it, then present it until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      spike_valid_q <= 1'b0;
      spike_axon_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifoEmpty) begin
            hold_q  <= fifoHead;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (destMatch) begin
            spike_axon_q  <= hold_q[AXON_MSB:AXON_LSB];
            spike_valid_q <= 1'b1;
            state_q       <= DELIVER;
          end else begin
            state_q <= IDLE;
          end
        end
        DELIVER: begin
          if (spike_ready) begin
            spike_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          spike_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  // Saturating event counters; both may step in the same cycle
  always_comb begin
    overflow_cnt_d = overflow_cnt_q;
    misroute_cnt_d = misroute_cnt_q;
    if (overflowEvent) begin
      overflow_cnt_d = CNT_W'(sat_inc(32'(overflow_cnt_q), CNT_W));
    end
    if (misrouteEvent) begin
      misroute_cnt_d = CNT_W'(sat_inc(32'(misroute_cnt_q), CNT_W));
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_cnt_q <= '0;
      misroute_cnt_q <= '0;
    end else begin
      overflow_cnt_q <= overflow_cnt_d;
      misroute_cnt_q <= misroute_cnt_d;
    end
  end

  assign pkt_full     = fifoFull;
  assign spike_valid  = spike_valid_q;
  assign spike_axon   = spike_axon_q;
  assign overflow_cnt = overflow_cnt_q;
  assign misroute_cnt = misroute_cnt_q;

endmodule

// File: tb/tb_spike_packet_receiver.sv
// Self-checking bench for spike_packet_receiver: directed scenarios plus a
// randomized run scored against a queue-based model of the delivered spikes.
module tb_spike_packet_receiver;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic [3:0]       local_x;
  logic [3:0]       local_y;
  logic [31:0]      pkt_in;
  logic             pkt_write;
  logic             pkt_full;
  logic             spike_valid;
  logic [15:0]      spike_axon;
  logic             spike_ready;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] overflow_cnt;
  logic [CNT_W-1:0] misroute_cnt;

  int passCount = 0;
  int checkCount = 0;

  spike_packet_receiver #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .local_x      (local_x),
    .local_y      (local_y),
    .pkt_in       (pkt_in),
    .pkt_write    (pkt_write),
    .pkt_full     (pkt_full),
    .spike_valid  (spike_valid),
    .spike_axon   (spike_axon),
    .spike_ready  (spike_ready),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt),
    .misroute_cnt (misroute_cnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if something stalls the sequence
  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  // Drive inputs at a falling edge and return at the next falling edge
  task automatic applyStimulus(input logic w, input logic [31:0] p, input logic r);
    pkt_write   = w;
    pkt_in      = p;
    spike_ready = r;
    @(negedge clk);
  endtask

  function automatic logic [15:0] axonOf(input logic [31:0] p);
    return 16'((p >> 8) & 32'h0000_FFFF);
  endfunction

  function automatic int satModel(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkCount++; if (spike_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%0h want=0", spike_valid); else passCount++;
    checkCount++; if (pkt_full !== 1'b0) $display("[TB] FAIL reset_full got=%0h want=0", pkt_full); else passCount++;
    checkCount++; if (fifo_level !== 3'd0) $display("[TB] FAIL reset_level got=%0d want=0", fifo_level); else passCount++;
    checkCount++; if (spike_axon !== 16'h0) $display("[TB] FAIL reset_axon got=%0h want=0", spike_axon); else passCount++;
    checkCount++; if (overflow_cnt !== 4'h0 || misroute_cnt !== 4'h0)
      $display("[TB] FAIL reset_counters got=%0h/%0h want=0/0", overflow_cnt, misroute_cnt); else passCount++;
    reset = 1'b0;
  endtask

  task automatic test_single;
    applyStimulus(1'b1, 32'h2345_0700, 1'b1);
    checkCount++; if (spike_valid !== 1'b0 || fifo_level !== 3'd1)
      $display("[TB] FAIL single_n1 got valid=%0h level=%0d want 0/1", spike_valid, fifo_level); else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCount++; if (spike_valid !== 1'b0) $display("[TB] FAIL single_n2 got=%0h want=0", spike_valid); else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCount++; if (spike_valid !== 1'b1 || spike_axon !== 16'h4507)
      $display("[TB] FAIL single_n3 got valid=%0h axon=%0h want 1/4507", spike_valid, spike_axon); else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCount++; if (spike_valid !== 1'b0 || spike_axon !== 16'h4507)
      $display("[TB] FAIL single_n4 got valid=%0h axon=%0h want 0/4507", spike_valid, spike_axon); else passCount++;
  endtask

  task automatic test_misroute;
    logic sawValid;
    sawValid = 1'b0;
    applyStimulus(1'b1, 32'h1145_0700, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sawValid |= spike_valid;
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    checkCount++; if (sawValid !== 1'b0) $display("[TB] FAIL misroute_valid got=1 want=0"); else passCount++;
    checkCount++; if (misroute_cnt !== 4'd1) $display("[TB] FAIL misroute_cnt got=%0d want=1", misroute_cnt); else passCount++;
    checkCount++; if (fifo_level !== 3'd0) $display("[TB] FAIL misroute_level got=%0d want=0", fifo_level); else passCount++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] pkts [6];
    int got;
    for (int i = 0; i < 6; i++) begin
      pkts[i] = {8'h23, 24'($urandom) & 24'hFFFF00};
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, pkts[i], 1'b0);
    end
    checkCount++; if (pkt_full !== 1'b1 || fifo_level !== 3'd4)
      $display("[TB] FAIL bp_full got full=%0h level=%0d want 1/4", pkt_full, fifo_level); else passCount++;
    checkCount++; if (overflow_cnt !== 4'd1) $display("[TB] FAIL bp_overflow got=%0d want=1", overflow_cnt); else passCount++;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (spike_valid) begin
        checkCount++; if (spike_axon !== axonOf(pkts[got]))
          $display("[TB] FAIL bp_order[%0d] got=%0h want=%0h", got, spike_axon, axonOf(pkts[got])); else passCount++;
        got++;
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    checkCount++; if (got != 5) $display("[TB] FAIL bp_count got=%0d want=5", got); else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCount++; if (fifo_level !== 3'd0 || pkt_full !== 1'b0 || spike_valid !== 1'b0)
      $display("[TB] FAIL bp_drain got level=%0d full=%0h valid=%0h want 0/0/0", fifo_level, pkt_full, spike_valid); else passCount++;
  endtask

  task automatic test_push_pop_at_depth_minus_one;
    logic [31:0] pkts [5];
    for (int i = 0; i < 5; i++) begin
      pkts[i] = {8'h23, 24'($urandom) & 24'hFFFF00};
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, pkts[i], 1'b0);
    end
    checkCount++; if (fifo_level !== 3'd3 || pkt_full !== 1'b0 || spike_valid !== 1'b1)
      $display("[TB] FAIL pp_setup got level=%0d full=%0h valid=%0h want 3/0/1", fifo_level, pkt_full, spike_valid); else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, pkts[4], 1'b0);
    checkCount++; if (fifo_level !== 3'd3 || pkt_full !== 1'b0)
      $display("[TB] FAIL pp_same_cycle got level=%0d full=%0h want 3/0", fifo_level, pkt_full); else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkCount++; if (spike_valid !== 1'b1 || spike_axon !== axonOf(pkts[1]))
      $display("[TB] FAIL pp_next got valid=%0h axon=%0h want 1/%0h", spike_valid, spike_axon, axonOf(pkts[1])); else passCount++;
  endtask

  task automatic test_reset_mid_delivery;
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    checkCount++; if (spike_valid !== 1'b0 || fifo_level !== 3'd0 || pkt_full !== 1'b0)
      $display("[TB] FAIL rst_mid got valid=%0h level=%0d full=%0h want 0/0/0", spike_valid, fifo_level, pkt_full); else passCount++;
    checkCount++; if (overflow_cnt !== 4'd0 || misroute_cnt !== 4'd0 || spike_axon !== 16'h0)
      $display("[TB] FAIL rst_mid_regs got ovf=%0d mis=%0d axon=%0h want 0/0/0", overflow_cnt, misroute_cnt, spike_axon); else passCount++;
    applyStimulus(1'b1, 32'h239A_BC00, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCount++; if (spike_valid !== 1'b1 || spike_axon !== 16'h9ABC)
      $display("[TB] FAIL rst_after got valid=%0h axon=%0h want 1/9abc", spike_valid, spike_axon); else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_random;
    logic [15:0] expQ [$];
    int          misroutes;
    logic        nextReady;
    logic        doWrite;
    logic        match;
    logic [7:0]  dest;
    logic [31:0] pkt;
    misroutes = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      nextReady = 1'($urandom_range(0, 1));
      if (spike_valid && nextReady) begin
        checkCount++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL rand_spurious got axon=%0h want none", spike_axon);
        end else begin
          if (spike_axon !== expQ[0]) $display("[TB] FAIL rand_axon got=%0h want=%0h", spike_axon, expQ[0]);
          else passCount++;
          void'(expQ.pop_front());
        end
      end
      doWrite = ($urandom_range(0, 1) == 1) && !pkt_full;
      match   = ($urandom_range(0, 7) != 0);
      dest    = 8'($urandom);
      if (match) dest = 8'h23;
      else if (dest == 8'h23) dest = 8'h32;
      pkt = {dest, 24'($urandom)};
      if (doWrite) begin
        if (match) expQ.push_back(axonOf(pkt));
        else misroutes++;
      end
      applyStimulus(doWrite, pkt, nextReady);
    end
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (spike_valid) begin
        checkCount++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL rand_drain_spurious got axon=%0h want none", spike_axon);
        end else begin
          if (spike_axon !== expQ[0]) $display("[TB] FAIL rand_drain_axon got=%0h want=%0h", spike_axon, expQ[0]);
          else passCount++;
          void'(expQ.pop_front());
        end
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    checkCount++; if (expQ.size() != 0) $display("[TB] FAIL rand_lost got=%0d pending want=0", expQ.size()); else passCount++;
    checkCount++; if (int'(misroute_cnt) != satModel(misroutes))
      $display("[TB] FAIL rand_misroute got=%0d want=%0d", misroute_cnt, satModel(misroutes)); else passCount++;
    checkCount++; if (fifo_level !== 3'd0 || overflow_cnt !== 4'd0)
      $display("[TB] FAIL rand_end got level=%0d ovf=%0d want 0/0", fifo_level, overflow_cnt); else passCount++;
  endtask

  task automatic test_overflow_saturation;
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b1, {8'h23, 24'($urandom)}, 1'b0);
    end
    checkCount++; if (overflow_cnt !== 4'd14) $display("[TB] FAIL sat_partial got=%0d want=14", overflow_cnt); else passCount++;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, {8'h23, 24'($urandom)}, 1'b0);
    end
    checkCount++; if (overflow_cnt !== 4'hF) $display("[TB] FAIL sat_hold got=%0h want=f", overflow_cnt); else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkCount++; if (overflow_cnt !== 4'hF || pkt_full !== 1'b1 || fifo_level !== 3'd4)
      $display("[TB] FAIL sat_idle got ovf=%0h full=%0h level=%0d want f/1/4", overflow_cnt, pkt_full, fifo_level); else passCount++;
  endtask

  // Scenario sequence
  initial begin
    reset       = 1'b1;
    local_x     = 4'd2;
    local_y     = 4'd3;
    pkt_in      = '0;
    pkt_write   = 1'b0;
    spike_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_misroute();
    test_back_to_back();
    test_push_pop_at_depth_minus_one();
    test_reset_mid_delivery();
    test_random();
    test_overflow_saturation();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
